reg_bank_write_arbiter: RTL and testbench

- Shares one 10-entry x 10-bit register bank (100-bit flat, free-running load register, no enable) among NREQ write requesters.
- Closes the bank's feedback loop: each cycle, every entry reloads its current value unless a granted write targets it.
- Round-robin arbitration, at most one write per cycle.
- Sits between requester logic and the bank register instance; the bank's own init value of 0 provides the entry reset values.

---
 rtl/reg_bank_write_arbiter_pkg.sv | 13 +
 rtl/reg_bank_write_arbiter_rr_arbiter.sv | 40 ++++
 rtl/reg_bank_write_arbiter.sv | 111 +++++++++++
 tb/tb_reg_bank_write_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_write_arbiter_pkg.sv
// Shared bank geometry and entry/bank types for the register-bank write arbiter.
// Bank packing matches the flat bus: entry 0 occupies the least significant bits.
package reg_bank_pkg;
   localparam int DEPTH = 10;
   localparam int WIDTH = 10;
   localparam int IDXW  = 4;

   typedef struct packed {
      logic [WIDTH-1:0] x;
   } entry_t;

   typedef entry_t [DEPTH-1:0] bank_t;
endpackage

// File: rtl/reg_bank_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: first valid requester at or after ptr_i (wrapping) wins.
// hold_i suppresses every grant; the grant is purely combinational.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [GW-1:0]   ptr_i,
   input  logic            hold_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [GW-1:0]   gnt_idx_o
);
   localparam int CW = GW + 1;

   logic          found_s;
   logic [CW-1:0] cand_s;

   // Wrapping priority search starting at ptr_i
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found_s   = 1'b0;
      cand_s    = '0;
      for (int o = 0; o < NREQ; o++) begin
         cand_s = {1'b0, ptr_i} + CW'(o);
         if (cand_s >= CW'(NREQ)) begin
            cand_s = cand_s - CW'(NREQ);
         end else begin
            cand_s = cand_s;
         end
         if (!hold_i && !found_s && req_i[cand_s]) begin
            found_s        = 1'b1;
            gnt_o[cand_s]  = 1'b1;
            gnt_idx_o      = cand_s[GW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end
endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Arbitrates NREQ write requesters onto a shared free-running register bank by
// feeding back bank_O as bank_I, overriding at most one entry per cycle.
module reg_bank_write_arbiter
   import reg_bank_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic                   CLK,
   input  logic                   ASYNCRESET,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*IDXW-1:0]   req_idx,
   input  logic [NREQ*WIDTH-1:0]  req_data,
   output logic [NREQ-1:0]        req_ready,
   input  logic                   hold,
   input  logic [DEPTH*WIDTH-1:0] bank_O,
   output logic [DEPTH*WIDTH-1:0] bank_I,
   output logic [IDXW-1:0]        last_grant,
   output logic                   wr_fire,
   output logic                   err_idx,
   input  logic                   err_clr
);
   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]  gnt_s;
   logic [GW-1:0]    gnt_idx_s;
   logic             gnt_any_s;
   logic [IDXW-1:0]  sel_idx_s;
   logic [WIDTH-1:0] sel_data_s;
   logic             idx_bad_s;
   bank_t            bank_cur_s;
   bank_t            bank_nxt_s;

   logic [GW-1:0]    rr_ptr_q,     rr_ptr_d;
   logic [IDXW-1:0]  last_grant_q, last_grant_d;
   logic             wr_fire_q,    wr_fire_d;
   logic             err_idx_q,    err_idx_d;

   rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_arb (
      .req_i     (req_valid),
      .ptr_i     (rr_ptr_q),
      .hold_i    (hold),
      .gnt_o     (gnt_s),
      .gnt_idx_o (gnt_idx_s)
   );

   assign gnt_any_s  = |gnt_s;
   assign req_ready  = gnt_s;
   assign bank_cur_s = bank_O;
   assign bank_I     = bank_nxt_s;

   // Select the winning requester's index and data, then build the next bank image
   always_comb begin
      sel_idx_s  = '0;
      sel_data_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_s[i]) begin
            sel_idx_s  = req_idx[i*IDXW +: IDXW];
            sel_data_s = req_data[i*WIDTH +: WIDTH];
         end else begin
            sel_idx_s  = sel_idx_s;
         end
      end
      idx_bad_s  = gnt_any_s && (sel_idx_s >= IDXW'(DEPTH));
      bank_nxt_s = bank_cur_s;
      for (int k = 0; k < DEPTH; k++) begin
         if (gnt_any_s && (sel_idx_s == IDXW'(k))) begin
            bank_nxt_s[k].x = sel_data_s;
         end else begin
            bank_nxt_s[k].x = bank_cur_s[k].x;
         end
      end
   end

   // Next-state for pointer, last grant, fire pulse and sticky error (set beats clear)
   always_comb begin
      if (gnt_any_s) begin
         rr_ptr_d     = (gnt_idx_s == GW'(NREQ - 1)) ? GW'(0) : gnt_idx_s + GW'(1);
         last_grant_d = IDXW'(gnt_idx_s);
      end else begin
         rr_ptr_d     = rr_ptr_q;
         last_grant_d = last_grant_q;
      end
      wr_fire_d = gnt_any_s;
      if (idx_bad_s) begin
         err_idx_d = 1'b1;
      end else if (err_clr) begin
         err_idx_d = 1'b0;
      end else begin
         err_idx_d = err_idx_q;
      end
   end

   // State registers
   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         rr_ptr_q     <= '0;
         last_grant_q <= '0;
         wr_fire_q    <= 1'b0;
         err_idx_q    <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         last_grant_q <= last_grant_d;
         wr_fire_q    <= wr_fire_d;
         err_idx_q    <= err_idx_d;
      end
   end

   assign last_grant = last_grant_q;
   assign wr_fire    = wr_fire_q;
   assign err_idx    = err_idx_q;
endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Directed, table-driven bench for reg_bank_write_arbiter; the bank itself is
// modelled here as a free-running register that resets to an alternating pattern.
module tb_reg_bank_write_arbiter;
   logic         CLK;
   logic         ASYNCRESET;
   logic [3:0]   req_valid;
   logic [15:0]  req_idx;
   logic [39:0]  req_data;
   logic [3:0]   req_ready;
   logic         hold;
   logic [99:0]  bank_O;
   logic [99:0]  bank_I;
   logic [3:0]   last_grant;
   logic         wr_fire;
   logic         err_idx;
   logic         err_clr;

   logic [99:0]  bank_pat;
   logic [99:0]  exp_bank;
   int           n_checks;
   int           n_fail;

   typedef struct {
      logic [3:0]  valid;
      logic [15:0] idx;
      logic [39:0] data;
      logic        hold;
      logic        clr;
      logic [3:0]  exp_ready;
      logic [3:0]  exp_lg;
      logic        exp_fire;
      logic        exp_err;
   } vec_t;

   vec_t vecs[20];

   reg_bank_write_arbiter #(.NREQ(4)) dut (
      .CLK        (CLK),
      .ASYNCRESET (ASYNCRESET),
      .req_valid  (req_valid),
      .req_idx    (req_idx),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .hold       (hold),
      .bank_O     (bank_O),
      .bank_I     (bank_I),
      .last_grant (last_grant),
      .wr_fire    (wr_fire),
      .err_idx    (err_idx),
      .err_clr    (err_clr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) bank_O <= bank_pat;
      else            bank_O <= bank_I;
   end

   task automatic check(input string name, input int n, input logic [99:0] act, input logic [99:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %h, expected %h", name, n, act, exp);
      end
   endtask

   function automatic logic [99:0] model_next(input logic [99:0] b, input vec_t v);
      logic [99:0] r;
      logic [3:0]  k;
      r = b;
      for (int g = 0; g < 4; g++) begin
         if (v.exp_ready[g]) begin
            k = v.idx[g*4 +: 4];
            if (k < 4'd10) r[k*10 +: 10] = v.data[g*10 +: 10];
         end
      end
      return r;
   endfunction

   task automatic run_vec(input vec_t v, input int n);
      logic [99:0] exp_next;
      req_valid = v.valid;
      req_idx   = v.idx;
      req_data  = v.data;
      hold      = v.hold;
      err_clr   = v.clr;
      exp_next  = model_next(exp_bank, v);
      @(negedge CLK);
      check("req_ready", n, 100'(req_ready), 100'(v.exp_ready));
      check("bank_I", n, bank_I, exp_next);
      @(posedge CLK);
      #1;
      exp_bank = exp_next;
      check("last_grant", n, 100'(last_grant), 100'(v.exp_lg));
      check("wr_fire", n, 100'(wr_fire), 100'(v.exp_fire));
      check("err_idx", n, 100'(err_idx), 100'(v.exp_err));
      check("bank_O", n, bank_O, exp_bank);
   endtask

   initial begin
      logic [15:0] idx_all;
      logic [39:0] dat_all;
      logic [15:0] idx_hold;
      logic [39:0] dat_hold;
      n_checks = 0;
      n_fail   = 0;
      for (int k = 0; k < 10; k++) bank_pat[k*10 +: 10] = (k % 2 == 0) ? 10'h155 : 10'h2AA;
      exp_bank = bank_pat;

      idx_all  = {4'd9, 4'd5, 4'd3, 4'd0};
      dat_all  = {10'h344, 10'h233, 10'h122, 10'h011};
      idx_hold = {4'd8, 4'd0, 4'd0, 4'd4};
      dat_hold = {10'h0F0, 10'h000, 10'h000, 10'h2D2};

      vecs[0]  = '{4'b0000, 16'h0000, 40'h0, 1'b0, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0};
      vecs[1]  = '{4'b0100, {4'd0, 4'd7, 4'd0, 4'd0}, {10'h000, 10'h3C5, 10'h000, 10'h000},
                   1'b0, 1'b0, 4'b0100, 4'd2, 1'b1, 1'b0};
      vecs[2]  = '{4'b1000, {4'd1, 12'h000}, {10'h0AA, 30'h0}, 1'b0, 1'b0, 4'b1000, 4'd3, 1'b1, 1'b0};
      vecs[3]  = '{4'b1111, idx_all, dat_all, 1'b0, 1'b0, 4'b0001, 4'd0, 1'b1, 1'b0};
      vecs[4]  = '{4'b1111, idx_all, dat_all, 1'b0, 1'b0, 4'b0010, 4'd1, 1'b1, 1'b0};
      vecs[5]  = '{4'b1111, idx_all, dat_all, 1'b0, 1'b0, 4'b0100, 4'd2, 1'b1, 1'b0};
      vecs[6]  = '{4'b1111, idx_all, dat_all, 1'b0, 1'b0, 4'b1000, 4'd3, 1'b1, 1'b0};
      vecs[7]  = '{4'b1111, idx_all, dat_all, 1'b0, 1'b0, 4'b0001, 4'd0, 1'b1, 1'b0};
      vecs[8]  = '{4'b1111, idx_all, dat_all, 1'b0, 1'b0, 4'b0010, 4'd1, 1'b1, 1'b0};
      vecs[9]  = '{4'b1111, idx_all, dat_all, 1'b0, 1'b0, 4'b0100, 4'd2, 1'b1, 1'b0};
      vecs[10] = '{4'b1111, idx_all, dat_all, 1'b0, 1'b0, 4'b1000, 4'd3, 1'b1, 1'b0};
      vecs[11] = '{4'b0010, {8'h00, 4'd12, 4'd0}, {20'h0, 10'h0FF, 10'h000}, 1'b0, 1'b0, 4'b0010, 4'd1, 1'b1, 1'b1};
      vecs[12] = '{4'b0010, {8'h00, 4'd13, 4'd0}, {20'h0, 10'h0F0, 10'h000}, 1'b0, 1'b1, 4'b0010, 4'd1, 1'b1, 1'b1};
      vecs[13] = '{4'b0000, 16'h0000, 40'h0, 1'b0, 1'b1, 4'b0000, 4'd1, 1'b0, 1'b0};
      vecs[14] = '{4'b1000, {4'd2, 12'h000}, {10'h1F0, 30'h0}, 1'b0, 1'b0, 4'b1000, 4'd3, 1'b1, 1'b0};
      vecs[15] = '{4'b1001, idx_hold, dat_hold, 1'b1, 1'b0, 4'b0000, 4'd3, 1'b0, 1'b0};
      vecs[16] = '{4'b1001, idx_hold, dat_hold, 1'b1, 1'b0, 4'b0000, 4'd3, 1'b0, 1'b0};
      vecs[17] = '{4'b1001, idx_hold, dat_hold, 1'b1, 1'b0, 4'b0000, 4'd3, 1'b0, 1'b0};
      vecs[18] = '{4'b1001, idx_hold, dat_hold, 1'b0, 1'b0, 4'b0001, 4'd0, 1'b1, 1'b0};
      vecs[19] = '{4'b1001, idx_hold, dat_hold, 1'b0, 1'b0, 4'b1000, 4'd3, 1'b1, 1'b0};

      ASYNCRESET = 1'b1;
      req_valid  = '0;
      req_idx    = '0;
      req_data   = '0;
      hold       = 1'b0;
      err_clr    = 1'b0;
      #1;
      check("reset wr_fire", -1, 100'(wr_fire), 100'(1'b0));
      check("reset err_idx", -1, 100'(err_idx), 100'(1'b0));
      check("reset last_grant", -1, 100'(last_grant), 100'(4'd0));
      check("reset req_ready", -1, 100'(req_ready), 100'(4'b0000));
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      ASYNCRESET = 1'b0;
      @(posedge CLK);
      #1;

      for (int n = 0; n < 20; n++) run_vec(vecs[n], n);

      // Reset asserted between edges while all four requesters are streaming
      req_valid = 4'b1111;
      req_idx   = {4'd9, 4'd5, 4'd14, 4'd0};
      req_data  = dat_all;
      hold      = 1'b0;
      err_clr   = 1'b0;
      @(posedge CLK);
      #1;
      check("stream grant0 lg", 100, 100'(last_grant), 100'(4'd0));
      @(posedge CLK);
      #1;
      check("stream bad idx err", 101, 100'(err_idx), 100'(1'b1));
      check("stream grant1 lg", 101, 100'(last_grant), 100'(4'd1));
      #2;
      ASYNCRESET = 1'b1;
      #1;
      check("midreset wr_fire", 102, 100'(wr_fire), 100'(1'b0));
      check("midreset err_idx", 102, 100'(err_idx), 100'(1'b0));
      check("midreset last_grant", 102, 100'(last_grant), 100'(4'd0));
      check("midreset bank_O", 102, bank_O, bank_pat);
      @(negedge CLK);
      ASYNCRESET = 1'b0;
      #1;
      check("restart ready", 103, 100'(req_ready), 100'(4'b0001));
      @(posedge CLK);
      #1;
      check("restart lg", 104, 100'(last_grant), 100'(4'd0));
      check("restart wr_fire", 104, 100'(wr_fire), 100'(1'b1));
      @(negedge CLK);
      check("restart next ready", 105, 100'(req_ready), 100'(4'b0010));
      req_valid = '0;
      @(posedge CLK);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
